// File: rtl/datapath_sequencer.sv
// Moore control sequencer for the Mini SRC datapath: register preload and
// instruction fetch plus ALU execute, with index-selected GP registers.
module datapath_sequencer #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int HILO_EN   = 1
) (
  input  logic                 Clock,
  input  logic                 Clear_n,
  input  logic                 Start,
  input  logic                 Cmd,
  input  logic [3:0]           Op,
  input  logic [REG_IDX_W-1:0] Ra,
  input  logic [REG_IDX_W-1:0] Rb,
  input  logic [REG_IDX_W-1:0] Rc,
  input  logic [DATA_W-1:0]    Data,
  input  logic [DATA_W-1:0]    Instr,
  output logic                 PCout,
  output logic                 Zlowout,
  output logic                 Zhighout,
  output logic                 MDRout,
  output logic                 MARin,
  output logic                 Zin,
  output logic                 PCin,
  output logic                 MDRin,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 IncPC,
  output logic                 Read,
  output logic                 AluEn,
  output logic [3:0]           AluOp,
  output logic [NUM_REGS-1:0]  Rin,
  output logic [NUM_REGS-1:0]  Rout,
  output logic [DATA_W-1:0]    Mdatain,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err
);

  typedef enum logic [3:0] {
    S_IDLE, S_ERR, S_LD_A, S_LD_B,
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6,
    S_DONE
  } state_t;

  localparam logic [REG_IDX_W:0] NREG_W = (REG_IDX_W+1)'(NUM_REGS);

  state_t state_reg, state_next;

  logic                 cmd_reg;
  logic [3:0]           op_reg;
  logic [REG_IDX_W-1:0] ra_reg, rb_reg, rc_reg;
  logic [DATA_W-1:0]    data_reg, instr_reg;

  // Legality of the command presented at Start; an index only counts if the
  // command actually uses it (MUL/DIV write LO, so Ra is unused there).
  logic a_bad, b_bad, c_bad;
  logic in_unary, in_hilo, op_bad, cmd_legal;

  assign a_bad    = {1'b0, Ra} >= NREG_W;
  assign b_bad    = {1'b0, Rb} >= NREG_W;
  assign c_bad    = {1'b0, Rc} >= NREG_W;
  assign in_unary = (Op == 4'hC) || (Op == 4'hD);
  assign in_hilo  = (Op == 4'h4) || (Op == 4'h6);
  assign op_bad   = (Op == 4'h5) || (Op == 4'hE) || (Op == 4'hF) ||
                    (in_hilo && (HILO_EN == 0));

  always_comb begin
    if (Cmd) begin
      cmd_legal = !a_bad;
    end else begin
      cmd_legal = !op_bad && !b_bad && !(c_bad && !in_unary) &&
                  !(a_bad && !in_hilo);
    end
  end

  logic lat_unary, lat_hilo;
  assign lat_unary = (op_reg == 4'hC) || (op_reg == 4'hD);
  assign lat_hilo  = (op_reg == 4'h4) || (op_reg == 4'h6);

  logic [NUM_REGS-1:0] ra_hot, rb_hot, rc_hot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_hot
      assign ra_hot[gi] = (ra_reg == REG_IDX_W'(gi));
      assign rb_hot[gi] = (rb_reg == REG_IDX_W'(gi));
      assign rc_hot[gi] = (rc_reg == REG_IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Command latches only load on an accepted Start; held otherwise.
  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      cmd_reg   <= 1'b0;
      op_reg    <= '0;
      ra_reg    <= '0;
      rb_reg    <= '0;
      rc_reg    <= '0;
      data_reg  <= '0;
      instr_reg <= '0;
    end else if ((state_reg == S_IDLE) && Start) begin
      cmd_reg   <= Cmd;
      op_reg    <= Op;
      ra_reg    <= Ra;
      rb_reg    <= Rb;
      rc_reg    <= Rc;
      data_reg  <= Data;
      instr_reg <= Instr;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (Start) begin
          if (!cmd_legal)  state_next = S_ERR;
          else if (Cmd)    state_next = S_LD_A;
          else             state_next = S_T0;
        end
      end
      S_ERR:  state_next = S_IDLE;
      S_LD_A: state_next = S_LD_B;
      S_LD_B: state_next = S_DONE;
      S_T0:   state_next = S_T1;
      S_T1:   state_next = S_T2;
      S_T2:   state_next = S_T3;
      S_T3:   state_next = lat_unary ? S_T5 : S_T4;
      S_T4:   state_next = S_T5;
      S_T5:   state_next = lat_hilo ? S_T6 : S_DONE;
      S_T6:   state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign AluOp = op_reg;

  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    AluEn    = 1'b0;
    Rin      = '0;
    Rout     = '0;
    Mdatain  = '0;
    Busy     = 1'b1;
    Done     = 1'b0;
    Err      = 1'b0;
    case (state_reg)
      S_IDLE: Busy = 1'b0;
      S_ERR: begin
        Busy = 1'b0;
        Done = 1'b1;
        Err  = 1'b1;
      end
      S_LD_A: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        Mdatain = data_reg;
      end
      S_LD_B: begin
        MDRout = 1'b1;
        Rin    = ra_hot;
      end
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        Mdatain = instr_reg;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Rout = rb_hot;
        // Unary ops compute straight from the B operand; no Y staging.
        if (lat_unary) begin
          AluEn = 1'b1;
          Zin   = 1'b1;
        end else begin
          Yin = 1'b1;
        end
      end
      S_T4: begin
        Rout  = rc_hot;
        AluEn = 1'b1;
        Zin   = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (lat_hilo) LOin = 1'b1;
        else          Rin  = ra_hot;
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      S_DONE: begin
        Busy = 1'b0;
        Done = 1'b1;
      end
      default: Busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: per-cycle expected strobe images
// are queued at command issue and compared at each falling edge.
module tb_datapath_sequencer;

  localparam int B_PCOUT = 14, B_ZLOW = 13, B_ZHIGH = 12, B_MDROUT = 11;
  localparam int B_MARIN = 10, B_ZIN = 9, B_PCIN = 8, B_MDRIN = 7;
  localparam int B_IRIN = 6, B_YIN = 5, B_HIIN = 4, B_LOIN = 3;
  localparam int B_INCPC = 2, B_READ = 1, B_ALUEN = 0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        clear_n, start0, start1, start2, cmd;
  logic [3:0]  op, ra, rb, rc;
  logic [31:0] data, instr;

  wire [14:0] strb0, strb1, strb2;
  wire [3:0]  aluop0, aluop1, aluop2;
  wire [15:0] rin0, rout0, rin1, rout1;
  wire [7:0]  rin2, rout2;
  wire [31:0] mdat0, mdat1, mdat2;
  wire        busy0, done0, err0, busy1, done1, err1, busy2, done2, err2;

  int total = 0;
  int bad = 0;

  datapath_sequencer u_dut (
    .Clock(clock), .Clear_n(clear_n), .Start(start0), .Cmd(cmd), .Op(op),
    .Ra(ra), .Rb(rb), .Rc(rc), .Data(data), .Instr(instr),
    .PCout(strb0[14]), .Zlowout(strb0[13]), .Zhighout(strb0[12]), .MDRout(strb0[11]),
    .MARin(strb0[10]), .Zin(strb0[9]), .PCin(strb0[8]), .MDRin(strb0[7]),
    .IRin(strb0[6]), .Yin(strb0[5]), .HIin(strb0[4]), .LOin(strb0[3]),
    .IncPC(strb0[2]), .Read(strb0[1]), .AluEn(strb0[0]), .AluOp(aluop0),
    .Rin(rin0), .Rout(rout0), .Mdatain(mdat0),
    .Busy(busy0), .Done(done0), .Err(err0)
  );

  datapath_sequencer #(.HILO_EN(0)) u_nohilo (
    .Clock(clock), .Clear_n(clear_n), .Start(start1), .Cmd(cmd), .Op(op),
    .Ra(ra), .Rb(rb), .Rc(rc), .Data(data), .Instr(instr),
    .PCout(strb1[14]), .Zlowout(strb1[13]), .Zhighout(strb1[12]), .MDRout(strb1[11]),
    .MARin(strb1[10]), .Zin(strb1[9]), .PCin(strb1[8]), .MDRin(strb1[7]),
    .IRin(strb1[6]), .Yin(strb1[5]), .HIin(strb1[4]), .LOin(strb1[3]),
    .IncPC(strb1[2]), .Read(strb1[1]), .AluEn(strb1[0]), .AluOp(aluop1),
    .Rin(rin1), .Rout(rout1), .Mdatain(mdat1),
    .Busy(busy1), .Done(done1), .Err(err1)
  );

  datapath_sequencer #(.NUM_REGS(8), .REG_IDX_W(4)) u_n8 (
    .Clock(clock), .Clear_n(clear_n), .Start(start2), .Cmd(cmd), .Op(op),
    .Ra(ra), .Rb(rb), .Rc(rc), .Data(data), .Instr(instr),
    .PCout(strb2[14]), .Zlowout(strb2[13]), .Zhighout(strb2[12]), .MDRout(strb2[11]),
    .MARin(strb2[10]), .Zin(strb2[9]), .PCin(strb2[8]), .MDRin(strb2[7]),
    .IRin(strb2[6]), .Yin(strb2[5]), .HIin(strb2[4]), .LOin(strb2[3]),
    .IncPC(strb2[2]), .Read(strb2[1]), .AluEn(strb2[0]), .AluOp(aluop2),
    .Rin(rin2), .Rout(rout2), .Mdatain(mdat2),
    .Busy(busy2), .Done(done2), .Err(err2)
  );

  typedef struct {
    string       nm;
    logic [14:0] s;
    logic [15:0] ri;
    logic [15:0] ro;
    logic [31:0] md;
    logic        bz;
    logic        dn;
    logic        er;
    logic [3:0]  ao;
  } exp_t;

  exp_t sbq[$];
  logic prev_dn;

  function automatic logic [14:0] sb(input int i);
    return 15'(1) << i;
  endfunction

  function automatic logic [15:0] hot(input logic [3:0] i);
    return 16'd1 << i;
  endfunction

  task automatic push(input string nm, input logic [14:0] s, input logic [15:0] ri,
                      input logic [15:0] ro, input logic [31:0] md, input logic bz,
                      input logic dn, input logic er, input logic [3:0] ao);
    exp_t e;
    e.nm = nm; e.s = s; e.ri = ri; e.ro = ro; e.md = md;
    e.bz = bz; e.dn = dn; e.er = er; e.ao = ao;
    sbq.push_back(e);
  endtask

  // Reference sequence for the default instance (HILO_EN=1, 16 registers).
  task automatic expect_cmd(input logic c, input logic [3:0] o, input logic [3:0] a,
                            input logic [3:0] b, input logic [3:0] cc,
                            input logic [31:0] d, input logic [31:0] ins);
    bit unary, hilo;
    unary = (o == 4'hC) || (o == 4'hD);
    hilo  = (o == 4'h4) || (o == 4'h6);
    if (!c && (o == 4'h5 || o == 4'hE || o == 4'hF)) begin
      push("err", '0, '0, '0, '0, 0, 1, 1, o);
    end else if (c) begin
      push("ld_a", sb(B_READ) | sb(B_MDRIN), '0, '0, d, 1, 0, 0, o);
      push("ld_b", sb(B_MDROUT), hot(a), '0, '0, 1, 0, 0, o);
      push("done", '0, '0, '0, '0, 0, 1, 0, o);
    end else begin
      push("t0", sb(B_PCOUT) | sb(B_MARIN) | sb(B_INCPC) | sb(B_ZIN), '0, '0, '0, 1, 0, 0, o);
      push("t1", sb(B_ZLOW) | sb(B_PCIN) | sb(B_READ) | sb(B_MDRIN), '0, '0, ins, 1, 0, 0, o);
      push("t2", sb(B_MDROUT) | sb(B_IRIN), '0, '0, '0, 1, 0, 0, o);
      if (unary) begin
        push("t3u", sb(B_ALUEN) | sb(B_ZIN), '0, hot(b), '0, 1, 0, 0, o);
      end else begin
        push("t3", sb(B_YIN), '0, hot(b), '0, 1, 0, 0, o);
        push("t4", sb(B_ALUEN) | sb(B_ZIN), '0, hot(cc), '0, 1, 0, 0, o);
      end
      if (hilo) begin
        push("t5lo", sb(B_ZLOW) | sb(B_LOIN), '0, '0, '0, 1, 0, 0, o);
        push("t6", sb(B_ZHIGH) | sb(B_HIIN), '0, '0, '0, 1, 0, 0, o);
      end else begin
        push("t5", sb(B_ZLOW), hot(a), '0, '0, 1, 0, 0, o);
      end
      push("done", '0, '0, '0, '0, 0, 1, 0, o);
    end
    push("idle", '0, '0, '0, '0, 0, 0, 0, o);
  endtask

  task automatic issue(input logic c, input logic [3:0] o, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] cc,
                       input logic [31:0] d, input logic [31:0] ins);
    cmd = c; op = o; ra = a; rb = b; rc = cc; data = d; instr = ins;
    start0 = 1'b1;
    prev_dn = 1'b0;
    expect_cmd(c, o, a, b, cc, d, ins);
    $display("issue cmd=%0d op=%h ra=%0d rb=%0d rc=%0d data=%h instr=%h",
             c, o, a, b, cc, d, ins);
  endtask

  // Pops up to n expected cycles (n<0: all). With hold, Start stays high
  // through the DONE cycle so its closing edge must ignore it.
  task automatic run_sb(input bit hold, input int n);
    exp_t e;
    int k;
    k = 0;
    while (sbq.size() > 0 && (n < 0 || k < n)) begin
      @(negedge clock);
      e = sbq.pop_front();
      k++;
      if (!hold || prev_dn) start0 = 1'b0;
      prev_dn = e.dn;
      total++;
      if (strb0 !== e.s) begin
        bad++; $display("FAIL %s strobes got=%h want=%h", e.nm, strb0, e.s);
      end
      total++;
      if (rin0 !== e.ri) begin
        bad++; $display("FAIL %s rin got=%h want=%h", e.nm, rin0, e.ri);
      end
      total++;
      if (rout0 !== e.ro) begin
        bad++; $display("FAIL %s rout got=%h want=%h", e.nm, rout0, e.ro);
      end
      total++;
      if (mdat0 !== e.md) begin
        bad++; $display("FAIL %s mdatain got=%h want=%h", e.nm, mdat0, e.md);
      end
      total++;
      if ({busy0, done0, err0} !== {e.bz, e.dn, e.er}) begin
        bad++; $display("FAIL %s busy/done/err got=%b want=%b", e.nm,
                        {busy0, done0, err0}, {e.bz, e.dn, e.er});
      end
      if (e.bz) begin
        total++;
        if (aluop0 !== e.ao) begin
          bad++; $display("FAIL %s aluop got=%h want=%h", e.nm, aluop0, e.ao);
        end
      end
    end
  endtask

  // Structural invariants, every cycle out of reset.
  always @(negedge clock) begin
    if (clear_n) begin
      total++;
      if ($countones({strb0[14:11], |rout0}) > 1) begin
        bad++; $display("FAIL bus_drivers got=%b want=at most one", {strb0[14:11], |rout0});
      end
      total++;
      if (!$onehot0(rin0) || !$onehot0(rout0)) begin
        bad++; $display("FAIL onehot rin=%h rout=%h want=one-hot or zero", rin0, rout0);
      end
    end
  end

  task automatic check_zero0(input string nm);
    total++;
    if ({strb0, rin0, rout0, mdat0, busy0, done0, err0, aluop0} !== '0) begin
      bad++;
      $display("FAIL %s outputs strb=%h rin=%h rout=%h mdat=%h bde=%b aluop=%h want=all 0",
               nm, strb0, rin0, rout0, mdat0, {busy0, done0, err0}, aluop0);
    end
  endtask

  task automatic test_reset;
    clear_n = 1'b0; start0 = 0; start1 = 0; start2 = 0;
    cmd = 0; op = 0; ra = 0; rb = 0; rc = 0; data = 0; instr = 0;
    repeat (2) @(negedge clock);
    check_zero0("reset");
    clear_n = 1'b1;
    repeat (2) @(negedge clock);
    check_zero0("idle_after_reset");
  endtask

  task automatic test_loads;
    issue(1, 0, 3, 0, 0, 32'h22, 0); run_sb(0, -1);
    issue(1, 0, 7, 0, 0, 32'h24, 0); run_sb(0, -1);
    issue(1, 0, 4, 0, 0, 32'h28, 0); run_sb(0, -1);
  endtask

  task automatic test_alu;
    issue(0, 4'h0, 4, 3, 7, 0, 32'h2A2B8000); run_sb(0, -1);
    issue(0, 4'h4, 0, 3, 7, 0, 32'h11110000); run_sb(0, -1);
    issue(0, 4'hC, 5, 2, 0, 0, 32'h0C520000); run_sb(0, -1);
    issue(0, 4'h9, 15, 15, 15, 0, 32'h4FF00000); run_sb(0, -1);
  endtask

  task automatic test_illegal;
    issue(0, 4'hE, 1, 2, 3, 0, 32'hDEAD0000); run_sb(0, -1);
  endtask

  task automatic test_side_instances;
    // MUL with HILO_EN=0, then ADD with Ra=8 on an 8-register build.
    for (int t = 0; t < 2; t++) begin
      cmd = 0; op = (t == 0) ? 4'h4 : 4'h2; ra = (t == 0) ? 4'd0 : 4'd8;
      rb = 3; rc = 7; instr = 32'h12345678;
      if (t == 0) start1 = 1'b1; else start2 = 1'b1;
      $display("issue side=%0d op=%h ra=%0d", t, op, ra);
      @(negedge clock);
      start1 = 1'b0; start2 = 1'b0;
      total++;
      if ((t == 0) ? ({done1, err1, busy1} !== 3'b110) : ({done2, err2, busy2} !== 3'b110)) begin
        bad++; $display("FAIL side%0d err_cycle done/err/busy got=%b/%b want=110", t,
                        {done1, err1, busy1}, {done2, err2, busy2});
      end
      total++;
      if ((t == 0) ? ({strb1, rin1, rout1, mdat1} !== '0) : ({strb2, rin2, rout2, mdat2} !== '0)) begin
        bad++; $display("FAIL side%0d err_strobes got=%h/%h want=0", t, strb1, strb2);
      end
      @(negedge clock);
      total++;
      if ((t == 0) ? ({done1, err1, busy1} !== 3'b000) : ({done2, err2, busy2} !== 3'b000)) begin
        bad++; $display("FAIL side%0d after_err got=%b/%b want=000", t,
                        {done1, err1, busy1}, {done2, err2, busy2});
      end
    end
  endtask

  task automatic test_back_to_back;
    // Start stays high for the whole ADD while the inputs wander.
    issue(0, 4'h2, 1, 2, 3, 0, 32'h22000000);
    run_sb(1, 2);
    op = 4'h9; ra = 4'd6; rb = 4'd6; rc = 4'd6; instr = 32'hFFFFFFFF;
    run_sb(1, -1);
  endtask

  task automatic test_reset_mid;
    issue(0, 4'h3, 1, 2, 3, 0, 32'h33000000);
    run_sb(0, 4);
    #2 clear_n = 1'b0;
    #1 check_zero0("reset_mid_t3");
    sbq.delete();
    @(negedge clock);
    check_zero0("reset_held");
    clear_n = 1'b1;
    @(negedge clock);
    check_zero0("idle_after_abort");
    issue(1, 0, 9, 0, 0, 32'hA5A5_0001, 0); run_sb(0, -1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t want=finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_loads;
    test_alu;
    test_illegal;
    test_side_instances;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
